// File: rtl/counter_pkg.sv
// Shared constants for the counter family (down-counter with reload, up-counter sibling).
package counter_pkg;

  localparam int CNT_W_DEFAULT = 4;

  // Up-counter sibling defaults to the same width as the down-counter.
  localparam int UP_CNT_W_DEFAULT = CNT_W_DEFAULT;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } cnt_state_t;

endpackage

// File: rtl/countdown4b_reload.sv
// Loadable down-counter with one-shot / periodic auto-reload and a one-clock terminal-count pulse.
// All state advances on the falling edge of clk.
module countdown4b_reload
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] d,
  output logic             tc,
  output logic             busy
);

  cnt_state_t       r_state;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_rl;
  logic             r_tc;
  logic             r_busy;

  cnt_state_t       w_state_nx;
  logic [WIDTH-1:0] w_d_nx;
  logic [WIDTH-1:0] w_rl_nx;
  logic             w_tc_nx;

  always_comb begin
    w_state_nx = r_state;
    w_d_nx     = r_d;
    w_rl_nx    = r_rl;
    w_tc_nx    = 1'b0;
    if (ld) begin
      w_d_nx     = din;
      w_rl_nx    = din;
      w_state_nx = (din != '0) ? RUN : IDLE;
    end else if (en && (r_state == RUN)) begin
      if (r_d > WIDTH'(1)) begin
        w_d_nx = r_d - WIDTH'(1);
      end else if (r_d == WIDTH'(1)) begin
        w_d_nx  = '0;
        w_tc_nx = 1'b1;
        if (!mode) w_state_nx = DONE;
      end else begin
        // Sitting at zero in RUN: reload if still periodic, otherwise finish without a second pulse.
        if (mode) w_d_nx = r_rl;
        else      w_state_nx = DONE;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_d     <= '0;
      r_rl    <= '0;
      r_tc    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_d     <= w_d_nx;
      r_rl    <= w_rl_nx;
      r_tc    <= w_tc_nx;
      r_busy  <= (w_state_nx == RUN);
    end
  end

  assign d    = r_d;
  assign tc   = r_tc;
  assign busy = r_busy;

endmodule

// File: tb/tb_countdown4b_reload.sv
// Scoreboard bench for countdown4b_reload: directed scenarios followed by randomized traffic.
module tb_countdown4b_reload;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ld = 1'b0;
  logic [W-1:0] din = '0;
  logic         en = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] d;
  logic         tc;
  logic         busy;

  countdown4b_reload #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld),
    .din  (din),
    .en   (en),
    .mode (mode),
    .d    (d),
    .tc   (tc),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic         tc;
    logic         busy;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  // Reference model: count value, stored reload value, whether a count is in progress.
  int m_cnt = 0;
  int m_reload = 0;
  bit m_running = 1'b0;
  bit m_pulse = 1'b0;

  task automatic model_step(input bit r, input bit l, input int dv, input bit e, input bit m);
    m_pulse = 1'b0;
    if (r) begin
      m_cnt = 0; m_reload = 0; m_running = 1'b0;
    end else if (l) begin
      m_cnt = dv; m_reload = dv; m_running = (dv != 0);
    end else if (e && m_running) begin
      if (m_cnt >= 2) m_cnt = m_cnt - 1;
      else if (m_cnt == 1) begin
        m_cnt = 0; m_pulse = 1'b1; m_running = m;
      end else if (m) m_cnt = m_reload;
      else m_running = 1'b0;
    end
  endtask

  task automatic drive(input bit r, input bit l, input int dv, input bit e, input bit m,
                       input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; ld = l; din = W'(dv); en = e; mode = m;
    model_step(r, l, dv, e, m);
    x.d = W'(m_cnt); x.tc = m_pulse; x.busy = m_running;
    exp_q.push_back(x);
    tag_q.push_back(tag);
  endtask

  exp_t  mon_e;
  string mon_t;
  initial begin
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_t = tag_q.pop_front();
        n_checks++;
        if ({d, tc, busy} !== mon_e) begin
          n_fail++;
          $display("FAIL %s: got d=%0d tc=%0b busy=%0b, expected d=%0d tc=%0b busy=%0b",
                   mon_t, d, tc, busy, mon_e.d, mon_e.tc, mon_e.busy);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  int  r_mode;
  bit  rr, rl, re;
  int  rdv;
  initial begin
    drive(1, 0, 0, 0, 0, "reset");
    drive(1, 1, 9, 1, 1, "rst_over_ld");

    // Reset mid-count, then stay idle with en high
    drive(0, 1, 9, 1, 0, "load9");
    drive(0, 0, 0, 1, 0, "dec8");
    drive(0, 0, 0, 1, 0, "dec7");
    drive(1, 1, 4, 1, 0, "rst_mid");
    repeat (3) drive(0, 0, 0, 1, 0, "idle_en_ignored");

    // One-shot from 3
    drive(0, 1, 3, 1, 0, "os_load3");
    repeat (3) drive(0, 0, 0, 1, 0, "os_count");
    repeat (6) drive(0, 0, 0, 1, 0, "os_done_hold");

    // Periodic from 2, 9 edges
    drive(0, 1, 2, 1, 1, "per_load2");
    repeat (8) drive(0, 0, 0, 1, 1, "per_count");

    // Stall at 2
    drive(0, 1, 4, 1, 0, "stall_load4");
    repeat (2) drive(0, 0, 0, 1, 0, "stall_dec");
    repeat (3) drive(0, 0, 0, 0, 0, "stall_hold");
    repeat (3) drive(0, 0, 0, 1, 0, "stall_resume");

    // Load collides with the 1->0 edge, then zero load
    drive(0, 1, 3, 1, 0, "col_load3");
    repeat (2) drive(0, 0, 0, 1, 0, "col_dec");
    drive(0, 1, 5, 1, 0, "col_load5");
    drive(0, 1, 0, 1, 0, "zero_load");
    repeat (2) drive(0, 0, 0, 1, 1, "zero_idle");

    // Full-width period
    drive(0, 1, 15, 1, 1, "wide_load15");
    repeat (34) drive(0, 0, 0, 1, 1, "wide_count");

    // Mode change mid-count: periodic to one-shot, and back
    drive(0, 1, 3, 1, 1, "mode_load3");
    drive(0, 0, 0, 1, 0, "mode_to_os");
    repeat (4) drive(0, 0, 0, 1, 0, "mode_os_finish");
    drive(0, 1, 2, 1, 0, "mode_load2");
    repeat (5) drive(0, 0, 0, 1, 1, "mode_to_per");

    r_mode = 0;
    for (int i = 0; i < 400; i++) begin
      rr  = ($urandom_range(0, 49) == 0);
      rl  = ($urandom_range(0, 7) == 0);
      rdv = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 15));
      re  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) r_mode = 1 - r_mode;
      drive(rr, rl, rdv, re, r_mode[0], "random");
    end

    drive(0, 0, 0, 0, 0, "final_hold");
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected responses unconsumed, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown4b_reload.md
COUNTDOWN4B_RELOAD -- requirements
Module: countdown4b_reload

Interface
REQ-001 Parameter WIDTH, default 4, counter and load-data width in bits.
REQ-002 clk  input  1  single clock; all state updates on the falling edge of clk.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 ld  input  1  load strobe; when high, din is captured on the next falling edge.
REQ-005 din  input  WIDTH  start/reload count.
REQ-006 en  input  1  count enable; qualifies every decrement and reload.
REQ-007 mode  input  1  0 = one-shot, 1 = periodic auto-reload; sampled on every edge.
REQ-008 d  output  WIDTH  current count, registered.
REQ-009 tc  output  1  terminal-count pulse, registered.
REQ-010 busy  output  1  high while the state is RUN, registered.

Function
REQ-011 The block SHALL have three states: IDLE, RUN and DONE.
REQ-012 The block SHALL hold a WIDTH-bit reload register rl that is written only by a load.
REQ-013 Priority on each edge SHALL be: rst, then ld, then en, then hold.
REQ-014 Load with din != 0: d <= din, rl <= din, state <= RUN, tc <= 0, from any state.
REQ-015 Load with din == 0: d <= 0, rl <= 0, state <= IDLE, tc <= 0 (zero count rejected, no pulse).
REQ-016 RUN with en=1 and d > 1: d <= d-1, tc <= 0.
REQ-017 RUN with en=1 and d == 1: d <= 0, tc <= 1.
REQ-018 In RUN after the 1->0 edge, one-shot mode: state <= DONE.
REQ-019 In RUN after the 1->0 edge, periodic mode: state stays RUN.
REQ-020 RUN, periodic, en=1 and d == 0: d <= rl, tc <= 0.
REQ-021 Periodic period: exactly rl+1 enabled edges between successive tc pulses.
REQ-022 RUN with en=0: d holds, tc <= 0 (tc is never stretched by a stall).
REQ-023 DONE and IDLE: d holds, tc <= 0, and en is ignored; only ld leaves these states.
REQ-024 tc SHALL be high for exactly one clock per terminal count.
REQ-025 When ld coincides with the d == 1 / en=1 edge, the load wins and tc <= 0.
REQ-026 A mode change mid-count SHALL take effect at the next zero crossing only.
REQ-027 The counter SHALL never underflow, i.e. never wrap from 0 to all-ones.
REQ-028 busy SHALL equal (state == RUN) as a registered output.
REQ-029 Decrement SHALL be WIDTH-bit unsigned; no external carry or borrow output.

Reset
REQ-030 rst high at a falling edge SHALL set: d = 0, rl = 0, tc = 0, busy = 0, state = IDLE.
REQ-031 rst SHALL override ld and en in the same cycle, including mid-count in RUN.
REQ-032 Outputs SHALL be defined from the first edge with rst high; no asynchronous path exists.

Structure
REQ-033 State encodings SHALL live in shared package counter_pkg, alongside the sibling up-counter constants: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10.
REQ-034 counter_pkg SHALL also hold the default width constant, value 4.
REQ-035 The block SHALL be a single module with no sub-module.
REQ-036 The next-state/count logic SHALL be in one combinational block and the registers in one falling-edge block.

Verification
REQ-037 Reset mid-count: rst for one edge while d = 7 in RUN -> d = 0, busy = 0, tc = 0 next edge, and the block stays IDLE with en = 1.
REQ-038 One-shot: ld din = 3, mode = 0, en = 1 -> d = 3, 2, 1, 0; tc high only on the edge d becomes 0; then DONE, busy = 0, d = 0 held for 5+ edges.
REQ-039 Periodic: ld din = 2, mode = 1, en = 1 for 9 edges -> d = 2, 1, 0, 2, 1, 0, 2, 1, 0; tc pulses every 3 edges; busy stays 1.
REQ-040 Stall: one-shot count from 4 with en low for 3 edges at d = 2 -> d holds 2, tc = 0, then resumes 1, 0 with a single tc pulse.
REQ-041 Collision and zero load: ld din = 5 on the d == 1 edge -> d = 5, tc = 0; then ld din = 0 -> d = 0, IDLE, no tc.
REQ-042 Width: ld din = 15 (WIDTH = 4), periodic -> 16-edge period, no 0->15 underflow outside reload.
